// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/coordinate generator with pixel clock-enable divider.
// Sync, enable and strobe outputs are registered from next-state counts so they align with h_count/v_count.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int CNT_W     = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    output logic             pix_en,
    output logic             h_sync,
    output logic             v_sync,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             display_en,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SS = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div, div_n;
    logic [CNT_W-1:0] h_n, v_n;
    logic             h_wrap, pe_n, hs_act, vs_act;

    // The registered pix_en is the advance qualifier, so counts move on the edge that ends a pix_en cycle.
    always_comb begin
        div_n  = (!enable || div == DIV_LAST) ? '0 : div + 1'b1;
        pe_n   = enable && div_n == DIV_LAST;
        h_wrap = pix_en && h_count == H_LAST;
        h_n    = !enable ? '0 : !pix_en ? h_count : h_wrap ? '0 : h_count + 1'b1;
        v_n    = !enable ? '0 : !h_wrap ? v_count : v_count == V_LAST ? '0 : v_count + 1'b1;
        hs_act = enable && h_n >= H_SS && h_n < H_SE;
        vs_act = enable && v_n >= V_SS && v_n < V_SE;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div         <= '0;
            pix_en      <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            display_en  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_n;
            pix_en      <= pe_n;
            h_count     <= h_n;
            v_count     <= v_n;
            h_sync      <= hs_act ? H_POL : ~H_POL;
            v_sync      <= vs_act ? V_POL : ~V_POL;
            display_en  <= enable && h_n < H_VIS && v_n < V_VIS;
            line_start  <= enable && h_wrap;
            frame_start <= enable && h_wrap && v_n == '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench driving three modes against a closed-form timing model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       pe, hs, vs, de, ls, fs;
        logic [9:0] h, v;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic pe_c, hs_c, vs_c, de_c, ls_c, fs_c;
    logic [9:0] h_a, v_a, h_b, v_b;
    logic [3:0] h_c, v_c;
    obs_t obs_a, obs_b, obs_c;
    obs_t q[$];
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Mode 0: default horizontal, 8-line frame. Mode 1: defaults, CLK_DIV 2, positive syncs. Mode 2: tiny mode.
    vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_a (
        .clk_in(clk), .reset(rst_n), .enable(en_a), .pix_en(pe_a), .h_sync(hs_a), .v_sync(vs_a),
        .h_count(h_a), .v_count(v_a), .display_en(de_a), .line_start(ls_a), .frame_start(fs_a));
    vga_timing_gen #(.H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(2)) u_b (
        .clk_in(clk), .reset(rst_n), .enable(en_b), .pix_en(pe_b), .h_sync(hs_b), .v_sync(vs_b),
        .h_count(h_b), .v_count(v_b), .display_en(de_b), .line_start(ls_b), .frame_start(fs_b));
    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_VISIBLE(4), .V_FRONT(1),
                     .V_SYNC(1), .V_BACK(1), .CNT_W(4)) u_c (
        .clk_in(clk), .reset(rst_n), .enable(en_c), .pix_en(pe_c), .h_sync(hs_c), .v_sync(vs_c),
        .h_count(h_c), .v_count(v_c), .display_en(de_c), .line_start(ls_c), .frame_start(fs_c));

    assign obs_a = {pe_a, hs_a, vs_a, de_a, ls_a, fs_a, h_a, v_a};
    assign obs_b = {pe_b, hs_b, vs_b, de_b, ls_b, fs_b, h_b, v_b};
    assign obs_c = {pe_c, hs_c, vs_c, de_c, ls_c, fs_c, 6'd0, h_c, 6'd0, v_c};

    function automatic obs_t pick(input int m);
        return m == 0 ? obs_a : m == 1 ? obs_b : obs_c;
    endfunction

    function automatic obs_t idle_val(input int m);
        obs_t o = '0;
        o.hs = (m != 1);
        o.vs = (m != 1);
        return o;
    endfunction

    // Expected outputs k edges after enable rose: the first pixel lasts one cycle, later ones CLK_DIV cycles.
    function automatic obs_t model(input int m, input int k);
        int d, hv, hf, hw, hb, vv, vf, vw, vb, ht, vt, n, np, h, v;
        bit pol;
        obs_t o;
        if (m == 0) begin d = 1; hv = 640; hf = 16; hw = 96; hb = 48; vv = 4; vf = 1; vw = 2; vb = 1; pol = 0; end
        else if (m == 1) begin d = 2; hv = 640; hf = 16; hw = 96; hb = 48; vv = 480; vf = 10; vw = 2; vb = 33; pol = 1; end
        else begin d = 1; hv = 8; hf = 2; hw = 2; hb = 2; vv = 4; vf = 1; vw = 1; vb = 1; pol = 0; end
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        n = (k + d - 2) / d;
        np = (k == 1) ? n : (k + d - 3) / d;
        h = n % ht;
        v = (n / ht) % vt;
        o.pe = (k % d) == d - 1;
        o.hs = (h >= hv + hf && h < hv + hf + hw) ? pol : !pol;
        o.vs = (v >= vv + vf && v < vv + vf + vw) ? pol : !pol;
        o.de = h < hv && v < vv;
        o.ls = n != np && h == 0;
        o.fs = o.ls && v == 0;
        o.h = 10'(h);
        o.v = 10'(v);
        return o;
    endfunction

    task automatic set_en(input int m, input logic val);
        if (m == 0) en_a = val;
        else if (m == 1) en_b = val;
        else en_c = val;
    endtask

    task automatic do_reset();
        en_a = 0; en_b = 0; en_c = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e, got;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            q.push_back(idle_val(m));
            e = q.pop_front();
            got = pick(m);
            tests++;
            if (got !== e) begin failed++; $display("FAIL reset_async m%0d: got %h expected %h", m, got, e); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            q.push_back(idle_val(m));
            e = q.pop_front();
            got = pick(m);
            tests++;
            if (got !== e) begin failed++; $display("FAIL reset_hold_disabled m%0d: got %h expected %h", m, got, e); end
        end
    endtask

    task automatic test_mode(input int m, input int cycles, input int exp_hs, input int exp_line,
                             input int exp_de, input int exp_fs);
        obs_t e, got;
        int hs_cnt = 0, de_cnt = 0, ls1 = 0, ls2 = 0, fs1 = 0;
        do_reset();
        set_en(m, 1'b1);
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk);
            q.push_back(model(m, k));
            @(negedge clk);
            got = pick(m);
            e = q.pop_front();
            tests++;
            if (got !== e) begin failed++; $display("FAIL mode%0d_cycle%0d: got %h expected %h", m, k, got, e); end
            if (k <= exp_line && got.hs == (m == 1)) hs_cnt++;
            if (k < exp_fs && got.de) de_cnt++;
            if (got.ls) begin
                if (ls1 == 0) ls1 = k;
                else if (ls2 == 0) ls2 = k;
            end
            if (got.fs && fs1 == 0) fs1 = k;
        end
        set_en(m, 1'b0);
        tests++;
        if (hs_cnt != exp_hs) begin failed++; $display("FAIL mode%0d_hsync_width: got %0d expected %0d", m, hs_cnt, exp_hs); end
        tests++;
        if (ls2 - ls1 != exp_line) begin failed++; $display("FAIL mode%0d_line_period: got %0d expected %0d", m, ls2 - ls1, exp_line); end
        tests++;
        if (fs1 != exp_fs) begin failed++; $display("FAIL mode%0d_first_frame_start: got %0d expected %0d", m, fs1, exp_fs); end
        tests++;
        if (de_cnt != exp_de) begin failed++; $display("FAIL mode%0d_display_count: got %0d expected %0d", m, de_cnt, exp_de); end
    endtask

    task automatic test_enable_restart();
        obs_t e, got;
        int fs_seen = 0;
        do_reset();
        en_a = 1'b1;
        for (int k = 1; k <= 4701; k++) begin
            @(posedge clk);
            q.push_back(model(0, k));
            @(negedge clk);
            got = obs_a;
            e = q.pop_front();
            if (k == 4701) begin
                tests++;
                if (got !== e || got.h != 700 || got.v != 5 || got.hs || got.vs) begin
                    failed++; $display("FAIL enable_pre_drop: got %h expected %h", got, e);
                end
            end
        end
        en_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            q.push_back(idle_val(0));
            @(negedge clk);
            got = obs_a;
            e = q.pop_front();
            tests++;
            if (got !== e) begin failed++; $display("FAIL enable_low_%0d: got %h expected %h", i, got, e); end
        end
        en_a = 1'b1;
        for (int k = 1; k <= 900; k++) begin
            @(posedge clk);
            q.push_back(model(0, k));
            @(negedge clk);
            got = obs_a;
            e = q.pop_front();
            if (got.fs) fs_seen++;
            if (k <= 3 || k == 801) begin
                tests++;
                if (got !== e) begin failed++; $display("FAIL restart_cycle%0d: got %h expected %h", k, got, e); end
            end
        end
        en_a = 1'b0;
        tests++;
        if (fs_seen != 0) begin failed++; $display("FAIL restart_no_frame_start: got %0d expected 0", fs_seen); end
    endtask

    task automatic test_async_reset();
        obs_t e, got;
        do_reset();
        en_a = 1'b1;
        repeat (300) @(negedge clk);
        q.push_back(model(0, 300));
        got = obs_a;
        e = q.pop_front();
        tests++;
        if (got !== e) begin failed++; $display("FAIL async_pre_reset: got %h expected %h", got, e); end
        #2 rst_n = 1'b0;
        #1;
        q.push_back(idle_val(0));
        got = obs_a;
        e = q.pop_front();
        tests++;
        if (got !== e) begin failed++; $display("FAIL async_reset_midline: got %h expected %h", got, e); end
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mode(0, 6500, 96, 800, 2560, 6401);
        test_mode(1, 3400, 192, 1600, 0, 0);
        test_mode(2, 250, 2, 14, 32, 99);
        test_enable_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
